// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Brief    : Shared op/state encodings and default latencies for md_sched.
//  Revision : 1.0
// ============================================================================
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int C_MULT_CYCLES_DEF = 5;
    localparam int C_DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the HI/LO unit for a busy window.
    function automatic logic is_md_arith(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module   : md_arith
//  Brief    : Combinational 32x32 multiply and divide core for HI/LO results.
//  Revision : 1.0
// ============================================================================
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic        w_sgn;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod_s;

    // Signed divide goes through magnitudes so 0x8000_0000 / -1 wraps to
    // 0x8000_0000 with a zero remainder instead of overflowing.
    always_comb begin
        w_sgn    = (op == MD_DIV);
        w_a_mag  = (w_sgn && a[31]) ? (32'd0 - a) : a;
        w_b_mag  = (w_sgn && b[31]) ? (32'd0 - b) : b;
        w_b_safe = (b == 32'd0) ? 32'd1 : w_b_mag;
        w_uq     = w_a_mag / w_b_safe;
        w_ur     = w_a_mag % w_b_safe;
        w_q      = (w_sgn && (a[31] ^ b[31])) ? (32'd0 - w_uq) : w_uq;
        w_r      = (w_sgn && a[31]) ? (32'd0 - w_ur) : w_ur;
        w_prod_u = {32'd0, a} * {32'd0, b};
        w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = w_prod_s;
            MD_MULTU: {res_hi, res_lo} = w_prod_u;
            MD_DIV, MD_DIVU: begin
                res_hi = w_r;
                res_lo = w_q;
                div0   = (b == 32'd0);
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
//  Module   : md_sched
//  Brief    : HI/LO multiply/divide scheduler with fixed busy windows and stall.
//  Revision : 1.0
// ============================================================================
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = C_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = C_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    md_state_e   r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_skip;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div0;

    md_arith u_arith (
        .op     (op),
        .a      (rs_val),
        .b      (rt_val),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo),
        .div0   (w_div0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= MD_IDLE;
            r_cnt       <= 4'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_skip <= 1'b0;
            r_busy      <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        if (is_md_arith(op)) begin
                            r_pend_hi   <= w_res_hi;
                            r_pend_lo   <= w_res_lo;
                            r_pend_skip <= w_div0;
                            r_cnt       <= (op[1]) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            r_busy      <= 1'b1;
                            r_state     <= MD_RUN;
                        end else if (op == MD_MTHI) begin
                            r_hi <= rs_val;
                        end else if (op == MD_MTLO) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                MD_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Commit on the last busy cycle so HI/LO are fresh as busy drops.
                    if (r_cnt == 4'd1) begin
                        if (!r_pend_skip) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= MD_IDLE;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stall_md = d_uses_md & (r_busy | (start & is_md_arith(op)));

    a_no_start_in_run: assert property (
        @(posedge clk) disable iff (reset) (r_state == MD_RUN) |-> !start
    );

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_sched
//  Brief    : Directed self-checking bench for md_sched.
//  Revision : 1.0
// ============================================================================
module tb_md_sched;

    localparam logic [2:0] C_MULT  = 3'd0;
    localparam logic [2:0] C_MULTU = 3'd1;
    localparam logic [2:0] C_DIV   = 3'd2;
    localparam logic [2:0] C_DIVU  = 3'd3;
    localparam logic [2:0] C_MTHI  = 3'd4;
    localparam logic [2:0] C_MTLO  = 3'd5;
    localparam logic [2:0] C_NONE  = 3'd7;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    int checks = 0;
    int errors = 0;
    int n;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_uses_md (d_uses_md),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .stall_md  (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one arithmetic op and count the cycles busy stays high.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; op = C_NONE;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = C_NONE; rs_val = 32'd0; rt_val = 32'd0;
        d_uses_md = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        // MULT -2 * 3
        run_op(C_MULT, 32'hFFFF_FFFE, 32'd3, n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2
        run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, n);
        check("div_cycles", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2: remainder follows dividend sign
        run_op(C_DIV, 32'd7, 32'hFFFF_FFFE, n);
        check("div_negb_lo", lo, 32'hFFFF_FFFD);
        check("div_negb_hi", hi, 32'd1);

        // DIV overflow corner
        run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);

        // DIVU treats operands as unsigned
        run_op(C_DIVU, 32'hFFFF_FFF9, 32'd2, n);
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'd1);

        // Signed vs unsigned product of 0x8000_0000 * 2
        run_op(C_MULT, 32'h8000_0000, 32'd2, n);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'd0);
        run_op(C_MULTU, 32'h8000_0000, 32'd2, n);
        check("multu_big_hi", hi, 32'd1);
        check("multu_big_lo", lo, 32'd0);

        // MTHI/MTLO then DIVU by zero leaves HI/LO untouched
        @(negedge clk);
        start = 1'b1; op = C_MTHI; rs_val = 32'h0000_1234;
        @(negedge clk);
        op = C_MTLO; rs_val = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0; op = C_NONE;
        check("mt_hi", hi, 32'h0000_1234);
        check("mt_lo", lo, 32'h0000_5678);
        check("mt_busy", {31'd0, busy}, 32'd0);
        run_op(C_DIVU, 32'h0000_DEAD, 32'd0, n);
        check("div0_cycles", n, 32'd10);
        check("div0_hi", hi, 32'h0000_1234);
        check("div0_lo", lo, 32'h0000_5678);

        // MULTU with a HI/LO user held in D
        d_uses_md = 1'b1;
        @(negedge clk);
        start = 1'b1; op = C_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        #1 check("stall_issue", {31'd0, stall_md}, 32'd1);
        @(negedge clk);
        start = 1'b0; op = C_NONE;
        n = 0;
        while (stall_md === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", n, 32'd5);
        check("stall_after", {31'd0, stall_md}, 32'd0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // Back-to-back MTHI/MTLO never stall
        @(negedge clk);
        start = 1'b1; op = C_MTHI; rs_val = 32'h0000_000A;
        #1 check("mthi_stall", {31'd0, stall_md}, 32'd0);
        @(negedge clk);
        op = C_MTLO; rs_val = 32'h0000_000B;
        #1 check("mtlo_stall", {31'd0, stall_md}, 32'd0);
        @(negedge clk);
        start = 1'b0; op = C_NONE;
        check("mt2_stall", {31'd0, stall_md}, 32'd0);
        check("mt2_hi", hi, 32'h0000_000A);
        check("mt2_lo", lo, 32'h0000_000B);
        d_uses_md = 1'b0;

        // op 6 is a no-op
        @(negedge clk);
        start = 1'b1; op = 3'd6; rs_val = 32'hFFFF_FFFF; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0; op = C_NONE;
        check("op6_busy", {31'd0, busy}, 32'd0);
        check("op6_hi", hi, 32'h0000_000A);
        check("op6_lo", lo, 32'h0000_000B);

        // Reset during a DIV aborts it with no later commit
        @(negedge clk);
        start = 1'b1; op = C_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; op = C_NONE;
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
